// File: rtl/bullet_collision_unit_pkg.sv
// Shared definitions for the bullet collision unit.
// Holds the default raster size, the frame FSM encoding and the
// saturating adder used for the score.
package bullet_collision_unit_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  // Wide enough for any SCORE_W+4 sum without internal overflow.
  localparam int unsigned SAT_MAX_W = 40;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    SCAN     = 2'd1,
    COMMIT   = 2'd2
  } state_e;

  // Add and clamp to 2^w - 1.
  function automatic logic [SAT_MAX_W-1:0] sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int unsigned          w
  );
    logic [SAT_MAX_W-1:0] sum;
    logic [SAT_MAX_W-1:0] lim;
    sum = a + b;
    lim = (SAT_MAX_W'(1) << w) - SAT_MAX_W'(1);
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/bullet_collision_unit_collision_matrix.sv
// Per-pixel bullet x asteroid overlap matrix, OR-reduced to hit vectors.
// Ports:
//   active_i      pixel lies in the visible area
//   bullet_pix_i  per-bullet lit flags
//   ast_pix_i     per-asteroid lit flags
//   ship_pix_i    ship lit flag
//   hit_b_c       bullets touching any asteroid at this pixel
//   hit_a_c       asteroids touched by any bullet at this pixel
//   hit_as_c      asteroids touched by the ship at this pixel
//   hit_ship_c    ship touching any asteroid at this pixel
// Macro SHIP_COLLISION_EN enables the ship terms; otherwise they are 0.
module bullet_collision_unit_collision_matrix #(
  parameter int unsigned NUM_BULLETS   = 4,
  parameter int unsigned NUM_ASTEROIDS = 8
) (
  input  logic                     active_i,
  input  logic [NUM_BULLETS-1:0]   bullet_pix_i,
  input  logic [NUM_ASTEROIDS-1:0] ast_pix_i,
  input  logic                     ship_pix_i,
  output logic [NUM_BULLETS-1:0]   hit_b_c,
  output logic [NUM_ASTEROIDS-1:0] hit_a_c,
  output logic [NUM_ASTEROIDS-1:0] hit_as_c,
  output logic                     hit_ship_c
);

  // Full pairwise AND, OR-reduced along each axis.
  always_comb begin
    hit_b_c = '0;
    hit_a_c = '0;
    for (int b = 0; b < int'(NUM_BULLETS); b++) begin
      for (int a = 0; a < int'(NUM_ASTEROIDS); a++) begin
        if (active_i && bullet_pix_i[b] && ast_pix_i[a]) begin
          hit_b_c[b] = 1'b1;
          hit_a_c[a] = 1'b1;
        end
      end
    end
  end

`ifdef SHIP_COLLISION_EN
  assign hit_ship_c = active_i & ship_pix_i & (|ast_pix_i);
  assign hit_as_c   = (active_i && ship_pix_i) ? ast_pix_i : '0;
`else
  logic unused_ship;
  assign unused_ship = ship_pix_i;
  assign hit_ship_c  = 1'b0;
  assign hit_as_c    = '0;
`endif

endmodule

// File: rtl/bullet_collision_unit.sv
// Pixel-rate collision detector: accumulates bullet/asteroid (and
// optionally ship/asteroid) overlaps over one frame and commits them at
// frame end as held kill vectors, updating a saturating score.
// Ports:
//   clk_25mhz, reset (async, active-high)
//   px, py          current raster position
//   bullet_pixel    per-bullet lit flags
//   asteroid_pixel  per-asteroid lit flags
//   ship_pixel      ship lit flag
//   bullet_kill     per-bullet kill, held one frame
//   asteroid_kill   per-asteroid kill, held one frame
//   ship_hit        ship struck, held one frame
//   score           saturating running score
//   frame_done      one-cycle pulse when a frame is committed
// Macro SHIP_COLLISION_EN enables ship collisions (default: ship_hit = 0).
module bullet_collision_unit
  import bullet_collision_unit_pkg::*;
#(
  parameter int unsigned NUM_BULLETS   = 4,
  parameter int unsigned NUM_ASTEROIDS = 8,
  parameter int unsigned H_ACTIVE      = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE      = V_ACTIVE_DEF,
  parameter int unsigned SCORE_W       = 16,
  parameter int unsigned POINTS        = 10
) (
  input  logic                     clk_25mhz,
  input  logic                     reset,
  input  logic [9:0]               px,
  input  logic [9:0]               py,
  input  logic [NUM_BULLETS-1:0]   bullet_pixel,
  input  logic [NUM_ASTEROIDS-1:0] asteroid_pixel,
  input  logic                     ship_pixel,
  output logic [NUM_BULLETS-1:0]   bullet_kill,
  output logic [NUM_ASTEROIDS-1:0] asteroid_kill,
  output logic                     ship_hit,
  output logic [SCORE_W-1:0]       score,
  output logic                     frame_done
);

  localparam int unsigned SUM_W = SCORE_W + 4;
  localparam int unsigned CNT_W = $clog2(NUM_ASTEROIDS + 1);

  // Input stage
  logic [9:0]               px_q, py_q;
  logic [NUM_BULLETS-1:0]   bpix_q;
  logic [NUM_ASTEROIDS-1:0] apix_q;
  logic                     spix_q;
  logic                     in_vld_q;

  state_e                   state_q, state_d;
  logic [NUM_BULLETS-1:0]   acc_b_q, acc_b_d;
  logic [NUM_ASTEROIDS-1:0] acc_a_q, acc_a_d;    // bullet-hit asteroids (scored)
  logic [NUM_ASTEROIDS-1:0] acc_as_q, acc_as_d;  // ship-hit asteroids (unscored)
  logic                     acc_ship_q, acc_ship_d;

  logic [NUM_BULLETS-1:0]   bullet_kill_q, bullet_kill_d;
  logic [NUM_ASTEROIDS-1:0] asteroid_kill_q, asteroid_kill_d;
  logic                     ship_hit_q, ship_hit_d;
  logic [SCORE_W-1:0]       score_q, score_d;
  logic                     frame_done_q, frame_done_d;

  logic                     active_c, sof_c, last_c;
  logic [NUM_BULLETS-1:0]   hit_b_c;
  logic [NUM_ASTEROIDS-1:0] hit_a_c, hit_as_c;
  logic                     hit_ship_c;
  logic [CNT_W-1:0]         pop_c;
  logic [SUM_W-1:0]         inc_c;
  logic                     clear_c, take_c;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_ASTEROIDS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(NUM_ASTEROIDS); i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  // in_vld_q keeps the cleared input registers from looking like a SOF.
  assign active_c = in_vld_q && (px_q < 10'(H_ACTIVE)) && (py_q < 10'(V_ACTIVE));
  assign sof_c    = in_vld_q && (px_q == 10'd0) && (py_q == 10'd0);
  assign last_c   = (px_q == 10'(H_ACTIVE - 1)) && (py_q == 10'(V_ACTIVE - 1));
  assign pop_c    = popcount(acc_a_q);
  assign inc_c    = SUM_W'(pop_c) * SUM_W'(POINTS);

  bullet_collision_unit_collision_matrix #(
    .NUM_BULLETS   (NUM_BULLETS),
    .NUM_ASTEROIDS (NUM_ASTEROIDS)
  ) u_matrix (
    .active_i     (active_c),
    .bullet_pix_i (bpix_q),
    .ast_pix_i    (apix_q),
    .ship_pix_i   (spix_q),
    .hit_b_c      (hit_b_c),
    .hit_a_c      (hit_a_c),
    .hit_as_c     (hit_as_c),
    .hit_ship_c   (hit_ship_c)
  );

  // Frame FSM and next-state of accumulators/outputs
  always_comb begin
    state_d         = state_q;
    acc_b_d         = acc_b_q;
    acc_a_d         = acc_a_q;
    acc_as_d        = acc_as_q;
    acc_ship_d      = acc_ship_q;
    bullet_kill_d   = bullet_kill_q;
    asteroid_kill_d = asteroid_kill_q;
    ship_hit_d      = ship_hit_q;
    score_d         = score_q;
    frame_done_d    = 1'b0;
    clear_c         = 1'b0;
    take_c          = 1'b0;

    case (state_q)
      WAIT_SOF: begin
        if (sof_c) begin
          state_d = SCAN;
          clear_c = 1'b1;
          take_c  = 1'b1;
        end
      end
      SCAN: begin
        // A jump back to (0,0) discards the partial frame.
        clear_c = sof_c;
        take_c  = 1'b1;
        if (last_c && !sof_c) state_d = COMMIT;
      end
      COMMIT: begin
        bullet_kill_d   = acc_b_q;
        asteroid_kill_d = acc_a_q | acc_as_q;
        ship_hit_d      = acc_ship_q;
        score_d         = SCORE_W'(sat_add(SAT_MAX_W'(score_q), SAT_MAX_W'(inc_c), SCORE_W));
        frame_done_d    = 1'b1;
        // The pixel seen this cycle belongs to the next frame.
        clear_c         = 1'b1;
        take_c          = 1'b1;
        state_d         = SCAN;
      end
      default: state_d = WAIT_SOF;
    endcase

    if (clear_c) begin
      acc_b_d    = '0;
      acc_a_d    = '0;
      acc_as_d   = '0;
      acc_ship_d = 1'b0;
    end
    if (take_c) begin
      acc_b_d    = acc_b_d | hit_b_c;
      acc_a_d    = acc_a_d | hit_a_c;
      acc_as_d   = acc_as_d | hit_as_c;
      acc_ship_d = acc_ship_d | hit_ship_c;
    end
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      px_q            <= '0;
      py_q            <= '0;
      bpix_q          <= '0;
      apix_q          <= '0;
      spix_q          <= 1'b0;
      in_vld_q        <= 1'b0;
      state_q         <= WAIT_SOF;
      acc_b_q         <= '0;
      acc_a_q         <= '0;
      acc_as_q        <= '0;
      acc_ship_q      <= 1'b0;
      bullet_kill_q   <= '0;
      asteroid_kill_q <= '0;
      ship_hit_q      <= 1'b0;
      score_q         <= '0;
      frame_done_q    <= 1'b0;
    end else begin
      px_q            <= px;
      py_q            <= py;
      bpix_q          <= bullet_pixel;
      apix_q          <= asteroid_pixel;
      spix_q          <= ship_pixel;
      in_vld_q        <= 1'b1;
      state_q         <= state_d;
      acc_b_q         <= acc_b_d;
      acc_a_q         <= acc_a_d;
      acc_as_q        <= acc_as_d;
      acc_ship_q      <= acc_ship_d;
      bullet_kill_q   <= bullet_kill_d;
      asteroid_kill_q <= asteroid_kill_d;
      ship_hit_q      <= ship_hit_d;
      score_q         <= score_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign bullet_kill   = bullet_kill_q;
  assign asteroid_kill = asteroid_kill_q;
  assign ship_hit      = ship_hit_q;
  assign score         = score_q;
  assign frame_done    = frame_done_q;

endmodule
